// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the byte-serial AES-128 encrypt control path.
// Encodings here are seen by the datapath, so do not renumber dp_op_e.
package aes_ctrl_pkg;

  localparam int AES_NR     = 10;
  localparam int AES_NBYTES = 16;
  localparam int AES_NCOLS  = 4;

  typedef enum logic [2:0] {
    DP_NOP    = 3'd0,
    DP_LOAD   = 3'd1,
    DP_ARK    = 3'd2,
    DP_SUB    = 3'd3,
    DP_SHIFT  = 3'd4,
    DP_MIX    = 3'd5,
    DP_UNLOAD = 3'd6
  } dp_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KEY,
    S_ARK,
    S_SUB,
    S_SHIFT,
    S_MIX,
    S_UNLOAD
  } seq_state_e;

endpackage

// File: rtl/aes_idx_counter.sv
// 4-bit byte/column index shared by every sequencer phase.
// tc flags the last byte (15) or, with short_tc, the last column (3).
module aes_idx_counter
  import aes_ctrl_pkg::*;
#(
  parameter int LONG_TC  = AES_NBYTES - 1,
  parameter int SHORT_TC = AES_NCOLS - 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       short_tc,
  output logic [3:0] idx,
  output logic       tc
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (enable) begin
      idx <= idx + 4'd1;
    end
  end

  assign tc = (idx == (short_tc ? 4'(SHORT_TC) : 4'(LONG_TC)));

endmodule

// File: rtl/aes_round_sequencer.sv
// Control FSM for the byte-serial AES-128 encrypt datapath: sequences LOAD,
// AddRoundKey, SubBytes, ShiftRows, MixColumns and UNLOAD; carries no data.
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int NBYTES = AES_NBYTES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       rk_req,
  output logic [3:0] rk_rnd,
  input  logic       rk_ack,
  output logic [2:0] dp_op,
  output logic [3:0] dp_idx,
  output logic [3:0] round
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  seq_state_e state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       done_q, done_d;
  logic       cnt_clear, cnt_en, cnt_tc;
  logic [3:0] idx;
  dp_op_e     op;

  aes_idx_counter #(
    .LONG_TC  (NBYTES - 1),
    .SHORT_TC (AES_NCOLS - 1)
  ) u_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .short_tc (state_q == S_MIX),
    .idx      (idx),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement leaves a variable unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    done_d    = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    if (abort) begin
      state_d   = S_IDLE;
      round_d   = '0;
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d   = S_LOAD;
          round_d   = '0;
          cnt_clear = 1'b1;
        end
        S_LOAD: if (in_valid) begin
          if (cnt_tc) begin
            state_d   = S_KEY;
            round_d   = '0;
            cnt_clear = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
        S_KEY: if (rk_ack) begin
          state_d   = S_ARK;
          cnt_clear = 1'b1;
        end
        S_ARK: if (cnt_tc) begin
          cnt_clear = 1'b1;
          if (round_q == LAST_ROUND) begin
            state_d = S_UNLOAD;
          end else begin
            state_d = S_SUB;
            round_d = round_q + 4'd1;
          end
        end else begin
          cnt_en = 1'b1;
        end
        S_SUB: if (cnt_tc) begin
          state_d   = S_SHIFT;
          cnt_clear = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
        // The final round has no MixColumns; go straight to its round key.
        S_SHIFT: begin
          cnt_clear = 1'b1;
          state_d   = (round_q == LAST_ROUND) ? S_KEY : S_MIX;
        end
        S_MIX: if (cnt_tc) begin
          state_d   = S_KEY;
          cnt_clear = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
        S_UNLOAD: if (out_ready) begin
          if (cnt_tc) begin
            state_d   = S_IDLE;
            round_d   = '0;
            done_d    = 1'b1;
            cnt_clear = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
        default: begin
          state_d   = S_IDLE;
          round_d   = '0;
          cnt_clear = 1'b1;
        end
      endcase
    end
  end

  // Outputs decode the registered state; only the LOAD strobe is qualified
  // by in_valid so the datapath captures the byte in the handshake cycle.
  always_comb begin
    op     = DP_NOP;
    dp_idx = '0;
    case (state_q)
      S_LOAD: begin
        if (in_valid) op = DP_LOAD;
        dp_idx = idx;
      end
      S_ARK:    begin op = DP_ARK;    dp_idx = idx; end
      S_SUB:    begin op = DP_SUB;    dp_idx = idx; end
      S_SHIFT:  op = DP_SHIFT;
      S_MIX:    begin op = DP_MIX;    dp_idx = idx; end
      S_UNLOAD: begin op = DP_UNLOAD; dp_idx = idx; end
      default:  op = DP_NOP;
    endcase
  end

  assign dp_op     = op;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_UNLOAD);
  assign rk_req    = (state_q == S_KEY);
  assign rk_rnd    = (state_q == S_KEY) ? round_q : 4'd0;
  assign round     = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench: table of idle/abort/reset vectors, then whole blocks
// compared against an op-trace model built from the AES round schedule.
module tb_aes_round_sequencer;

  localparam int NR     = 10;
  localparam int BUDGET = 3000;
  localparam logic [2:0] OP_NOP = 3'd0, OP_LOAD = 3'd1, OP_ARK = 3'd2, OP_SUB = 3'd3,
                         OP_SHIFT = 3'd4, OP_MIX = 3'd5, OP_UNLOAD = 3'd6;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, in_valid, out_ready, rk_ack;
  logic       busy, done, in_ready, out_valid, rk_req;
  logic [3:0] rk_rnd, dp_idx, round;
  logic [2:0] dp_op;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  aes_round_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rk_req    (rk_req),
    .rk_rnd    (rk_rnd),
    .rk_ack    (rk_ack),
    .dp_op     (dp_op),
    .dp_idx    (dp_idx),
    .round     (round)
  );

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] idx;
  } ev_t;

  // stim = {rst_n, start, abort, in_valid, out_ready, rk_ack}; flags = {busy, in_ready}
  typedef struct {
    logic [5:0] stim;
    logic [1:0] flags;
    logic [2:0] op;
    logic [3:0] idx;
  } vec_t;

  ev_t  exp_q[$];
  ev_t  got_q[$];
  int   rk_q[$];
  int   hold[16];
  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_idle(input string name);
    check(name, 32'({busy, done, in_ready, out_valid, rk_req, rk_rnd, dp_op, dp_idx, round}), 32'd0);
  endtask

  task automatic drive_idle();
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; rk_ack = 1'b0;
  endtask

  // Datapath op stream for one block, straight from the AES-128 round schedule.
  task automatic build_expected();
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back({OP_LOAD, 4'(i)});
    for (int r = 0; r <= NR; r++) begin
      if (r > 0) begin
        for (int i = 0; i < 16; i++) exp_q.push_back({OP_SUB, 4'(i)});
        exp_q.push_back({OP_SHIFT, 4'd0});
        if (r < NR) for (int c = 0; c < 4; c++) exp_q.push_back({OP_MIX, 4'(c)});
      end
      for (int i = 0; i < 16; i++) exp_q.push_back({OP_ARK, 4'(i)});
    end
    for (int i = 0; i < 16; i++) exp_q.push_back({OP_UNLOAD, 4'(i)});
  endtask

  // Runs one block from IDLE. stop_mode 1 aborts in MIX of round 5,
  // stop_mode 2 resets on UNLOAD byte 7. Called and returns at posedge+1.
  task automatic run_block(input string tag, input int ack_round, input int ack_delay,
                           input bit rand_bp, input bit sub_start, input bit restart,
                           input int stop_mode);
    int cyc = 0, last_hs = -1, first_ov = -1, done_cyc = -1, ack_wait = 0, bad = -1;
    int n_load = 0, n_sub = 0, n_shift = 0, n_mix = 0, n_unload = 0, extra = 0;
    bit finished = 0, stop_armed = 0, prev_ov = 0, prev_ready = 0, prev_rk = 0;
    logic [3:0] prev_idx = '0, prev_rnd = '0;
    got_q.delete();
    rk_q.delete();
    foreach (hold[i]) hold[i] = 0;
    while (!finished && cyc < BUDGET) begin
      if (stop_armed) begin
        drive_idle();
        @(negedge clk);
        check_idle({tag, "_outputs_after_stop"});
        finished = 1;
      end else begin
        start     = (cyc == 0) || (sub_start && dp_op == OP_SUB) || (restart && done);
        abort     = 1'b0;
        rst_n     = 1'b1;
        in_valid  = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rk_req && int'(rk_rnd) == ack_round && ack_wait < ack_delay) begin
          rk_ack = 1'b0;
          ack_wait++;
        end else if (rk_req) begin
          rk_ack = 1'b1;
        end else begin
          rk_ack = rand_bp ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (stop_mode == 1 && dp_op == OP_MIX && round == 4'd5) begin
          abort = 1'b1;
          stop_armed = 1;
        end
        if (stop_mode == 2 && dp_op == OP_UNLOAD && dp_idx == 4'd7) begin
          rst_n = 1'b0;
          stop_armed = 1;
        end
        @(negedge clk);
        if (in_ready) check({tag, "_load_strobe"}, 32'(dp_op), 32'(in_valid ? OP_LOAD : OP_NOP));
        if (in_valid && in_ready) last_hs = cyc;
        if (dp_op inside {OP_LOAD, OP_ARK, OP_SUB, OP_SHIFT, OP_MIX}) got_q.push_back({dp_op, dp_idx});
        if (out_valid && out_ready) got_q.push_back({dp_op, dp_idx});
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (prev_ov && !prev_ready)
          check({tag, "_out_valid_hold"}, 32'({out_valid, dp_idx}), 32'({1'b1, prev_idx}));
        if (rk_req) begin
          check({tag, "_key_dp_nop"}, 32'(dp_op), 32'(OP_NOP));
          if (!prev_rk) rk_q.push_back(int'(rk_rnd));
          else check({tag, "_rk_rnd_stable"}, 32'(rk_rnd), 32'(prev_rnd));
          hold[rk_rnd]++;
        end
        if (done) begin
          done_cyc = cyc;
          check({tag, "_done_not_busy"}, 32'(busy), 32'd0);
          finished = 1;
        end
        prev_ov = out_valid; prev_ready = out_ready; prev_idx = dp_idx;
        prev_rk = rk_req; prev_rnd = rk_rnd;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_completed"}, 32'(finished), 32'd1);
    if (stop_mode != 0) begin
      check({tag, "_stop_reached"}, 32'(stop_armed), 32'd1);
    end else if (finished) begin
      build_expected();
      check({tag, "_trace_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        if (got_q[i] != exp_q[i]) begin
          bad = i;
          $display("  %s trace diverges at %0d: op %0d idx %0d, model op %0d idx %0d",
                   tag, i, got_q[i].op, got_q[i].idx, exp_q[i].op, exp_q[i].idx);
          break;
        end
      end
      check({tag, "_trace_first_diff"}, 32'(bad), 32'(-1));
      foreach (got_q[i]) begin
        case (got_q[i].op)
          OP_LOAD:   n_load++;
          OP_SUB:    if (got_q[i].idx == 4'd0) n_sub++;
          OP_SHIFT:  n_shift++;
          OP_MIX:    if (got_q[i].idx == 4'd0) n_mix++;
          OP_UNLOAD: n_unload++;
          default: ;
        endcase
      end
      check({tag, "_load_count"}, 32'(n_load), 32'd16);
      check({tag, "_sub_phases"}, 32'(n_sub), 32'd10);
      check({tag, "_shift_phases"}, 32'(n_shift), 32'd10);
      check({tag, "_mix_phases"}, 32'(n_mix), 32'd9);
      check({tag, "_unload_count"}, 32'(n_unload), 32'd16);
      check({tag, "_rk_count"}, 32'(rk_q.size()), 32'(NR + 1));
      for (int i = 0; i < rk_q.size() && i <= NR; i++)
        check($sformatf("%s_rk_seq%0d", tag, i), 32'(rk_q[i]), 32'(i));
      for (int r = 0; r <= NR; r++)
        check($sformatf("%s_rk_hold%0d", tag, r), 32'(hold[r]), 32'((r == ack_round) ? 1 + ack_delay : 1));
      if (!rand_bp) begin
        extra = (ack_round >= 0) ? ack_delay : 0;
        // Cycles strictly between the last LOAD handshake and the first UNLOAD cycle.
        check({tag, "_latency"}, 32'(first_ov - last_hs - 1), 32'(393 + extra));
        check({tag, "_done_gap"}, 32'(done_cyc - first_ov), 32'd16);
      end
    end
  endtask

  initial begin
    vecs = '{
      '{6'b100000, 2'b00, OP_NOP,  4'd0},
      '{6'b100100, 2'b00, OP_NOP,  4'd0},
      '{6'b100010, 2'b00, OP_NOP,  4'd0},
      '{6'b100001, 2'b00, OP_NOP,  4'd0},
      '{6'b100111, 2'b00, OP_NOP,  4'd0},
      '{6'b110000, 2'b00, OP_NOP,  4'd0},
      '{6'b100100, 2'b11, OP_LOAD, 4'd0},
      '{6'b100000, 2'b11, OP_NOP,  4'd1},
      '{6'b100100, 2'b11, OP_LOAD, 4'd1},
      '{6'b110100, 2'b11, OP_LOAD, 4'd2},
      '{6'b101100, 2'b11, OP_LOAD, 4'd3},
      '{6'b100000, 2'b00, OP_NOP,  4'd0},
      '{6'b111000, 2'b00, OP_NOP,  4'd0},
      '{6'b100000, 2'b00, OP_NOP,  4'd0},
      '{6'b110000, 2'b00, OP_NOP,  4'd0},
      '{6'b000100, 2'b11, OP_LOAD, 4'd0},
      '{6'b100000, 2'b00, OP_NOP,  4'd0}
    };

    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset_state");
    @(posedge clk);
    #1;

    // Each vector: inputs for this cycle, outputs expected in this same cycle.
    foreach (vecs[i]) begin
      {rst_n, start, abort, in_valid, out_ready, rk_ack} = vecs[i].stim;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            32'({busy, done, in_ready, out_valid, rk_req, dp_op, dp_idx, round}),
            32'({vecs[i].flags[1], 1'b0, vecs[i].flags[0], 1'b0, 1'b0, vecs[i].op, vecs[i].idx, 4'd0}));
      @(posedge clk);
      #1;
    end
    drive_idle();

    run_block("nominal", -1, 0, 1'b0, 1'b0, 1'b0, 0);
    drive_idle();
    @(negedge clk);
    check("done_one_cycle", 32'({done, busy}), 32'd0);
    @(posedge clk);
    #1;

    run_block("backpressure_a", -1, 0, 1'b1, 1'b0, 1'b0, 0);
    run_block("backpressure_b", -1, 0, 1'b1, 1'b0, 1'b0, 0);
    run_block("ack_delay_r3", 3, 5, 1'b0, 1'b0, 1'b0, 0);
    run_block("start_while_busy", -1, 0, 1'b0, 1'b1, 1'b1, 0);

    // start in the done cycle must have launched a fresh LOAD.
    drive_idle();
    @(negedge clk);
    check("restart_in_done_cycle", 32'({busy, in_ready, dp_op, dp_idx, round}),
          32'({1'b1, 1'b1, OP_NOP, 4'd0, 4'd0}));
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check_idle("abort_in_load");
    @(posedge clk);
    #1;

    run_block("abort_mix_r5", -1, 0, 1'b0, 1'b0, 1'b0, 1);
    run_block("reset_unload_b7", -1, 0, 1'b0, 1'b0, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
